// File: rtl/odometer_accum.sv
// odometer_accum: accumulates encoder INCR/DECR samples into whole units and
// a sub-unit tick fraction, with error counting and a latched FAULT state.
module odometer_accum #(
    parameter int TICKS_PER_UNIT = 16,
    parameter int UNIT_W         = 16,
    parameter int ERR_LIMIT      = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid,
    input  logic [2:0]        code,
    input  logic              clear,
    output logic [UNIT_W-1:0] unit_count,
    output logic [7:0]        tick_frac,
    output logic              unit_pulse,
    output logic [7:0]        err_count,
    output logic              fault
);
    typedef enum logic {RUN, FLT} state_t;

    localparam logic [7:0]        TOP  = 8'(TICKS_PER_UNIT - 1);
    localparam logic [UNIT_W-1:0] UMAX = '1;
    localparam logic [UNIT_W-1:0] U1   = 1;
    localparam logic [3:0]        LIM  = 4'(ERR_LIMIT);

    state_t     state;
    logic [3:0] consec;
    logic [3:0] consec_nx;
    logic       inc, dec, err;

    // Anything that is not a clean one-hot move or all-zero is an error.
    assign inc       = code == 3'b100;
    assign dec       = code == 3'b010;
    assign err       = !(inc || dec || code == 3'b000);
    assign consec_nx = consec == 4'hf ? consec : consec + 4'd1;
    assign fault     = state == FLT;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RUN;
            consec     <= 4'd0;
            unit_count <= '0;
            tick_frac  <= 8'd0;
            unit_pulse <= 1'b0;
            err_count  <= 8'd0;
        end else if (clear) begin
            state      <= RUN;
            consec     <= 4'd0;
            unit_count <= '0;
            tick_frac  <= 8'd0;
            unit_pulse <= 1'b0;
            err_count  <= 8'd0;
        end else begin
            unit_pulse <= 1'b0;
            if (valid && err) begin
                consec    <= consec_nx;
                err_count <= err_count == 8'hff ? err_count : err_count + 8'd1;
                if (consec_nx >= LIM)
                    state <= FLT;
            end else if (valid) begin
                consec <= 4'd0;
                // Moves are frozen in FAULT; saturate at both ends of the range.
                if (state == RUN && inc) begin
                    if (tick_frac != TOP)
                        tick_frac <= tick_frac + 8'd1;
                    else if (unit_count != UMAX) begin
                        tick_frac  <= 8'd0;
                        unit_count <= unit_count + U1;
                        unit_pulse <= 1'b1;
                    end
                end
                if (state == RUN && dec) begin
                    if (tick_frac != 8'd0)
                        tick_frac <= tick_frac - 8'd1;
                    else if (unit_count != '0) begin
                        tick_frac  <= TOP;
                        unit_count <= unit_count - U1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_odometer_accum.sv
// tb_odometer_accum: randomized scoreboard bench with a position-based reference model.
module tb_odometer_accum;
    localparam int T  = 16;
    localparam int UW = 4;
    localparam int EL = 3;
    localparam longint MAXP = (longint'(1) << UW) * T - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          valid = 1'b0;
    logic          clear = 1'b0;
    logic [2:0]    code = 3'b000;
    logic [UW-1:0] unit_count;
    logic [7:0]    tick_frac;
    logic          unit_pulse;
    logic [7:0]    err_count;
    logic          fault;

    always #5 clk = ~clk;

    odometer_accum #(.TICKS_PER_UNIT(T), .UNIT_W(UW), .ERR_LIMIT(EL)) dut (
        .clk(clk), .rst(rst), .valid(valid), .code(code), .clear(clear),
        .unit_count(unit_count), .tick_frac(tick_frac), .unit_pulse(unit_pulse),
        .err_count(err_count), .fault(fault)
    );

    typedef struct packed {
        logic [UW-1:0] u;
        logic [7:0]    f;
        logic          p;
        logic [7:0]    e;
        logic          flt;
    } exp_t;

    exp_t q[$];
    int compared = 0;
    int mismatched = 0;

    // Reference model: a single linear tick position plus error bookkeeping.
    longint pos;
    int     m_err, m_consec;
    bit     m_fault, m_pulse;

    function automatic exp_t snap();
        exp_t e;
        e.u = UW'(pos / T);
        e.f = 8'(pos % T);
        e.p = m_pulse;
        e.e = 8'(m_err);
        e.flt = m_fault;
        return e;
    endfunction

    function automatic exp_t got();
        exp_t a;
        a.u = unit_count;
        a.f = tick_frac;
        a.p = unit_pulse;
        a.e = err_count;
        a.flt = fault;
        return a;
    endfunction

    task automatic model_reset();
        pos = 0;
        m_err = 0;
        m_consec = 0;
        m_fault = 0;
        m_pulse = 0;
    endtask

    task automatic check(input string name, input exp_t a, input exp_t e);
        compared++;
        if (a !== e) begin
            mismatched++;
            $display("FAIL %s: got u=%0d f=%0d p=%0b e=%0d flt=%0b, expected u=%0d f=%0d p=%0b e=%0d flt=%0b",
                     name, a.u, a.f, a.p, a.e, a.flt, e.u, e.f, e.p, e.e, e.flt);
        end
    endtask

    task automatic drive(input bit v, input logic [2:0] c, input bit cl);
        @(negedge clk);
        valid = v;
        code = c;
        clear = cl;
        if (cl) model_reset();
        else begin
            m_pulse = 0;
            if (v) begin
                if (c == 3'b100 || c == 3'b010 || c == 3'b000) begin
                    m_consec = 0;
                    if (!m_fault && c == 3'b100 && pos < MAXP) begin
                        pos++;
                        m_pulse = (pos % T) == 0;
                    end else if (!m_fault && c == 3'b010 && pos > 0)
                        pos--;
                end else begin
                    if (m_err < 255) m_err++;
                    if (m_consec < 15) m_consec++;
                    if (m_consec >= EL) m_fault = 1;
                end
            end
        end
        q.push_back(snap());
    endtask

    task automatic rep(input int n, input bit v, input logic [2:0] c);
        for (int i = 0; i < n; i++) drive(v, c, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        valid = 0;
        clear = 0;
        #2 rst = 1;
        #1;
        model_reset();
        check("async_rst", got(), snap());
        q.push_back(snap());
        @(negedge clk);
        rst = 0;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) check("scoreboard", got(), q.pop_front());
        end
    end

    initial begin
        model_reset();
        #1 check("reset_state", got(), snap());
        #1 rst = 0;
        rep(16, 1, 3'b100);
        rep(1, 1, 3'b010);
        rep(16, 1, 3'b010);
        rep(2, 1, 3'b001);
        rep(1, 1, 3'b100);
        rep(3, 1, 3'b001);
        rep(5, 1, 3'b100);
        drive(1, 3'b100, 1);
        rep(1, 1, 3'b110);
        rep(20, 0, 3'b100);
        rep(80, 1, 3'b100);
        rep(3, 1, 3'b001);
        do_reset();
        rep(260, 1, 3'b100);
        rep(3, 1, 3'b010);
        rep(2, 1, 3'b100);
        for (int i = 0; i < 3000; i++) begin
            int r;
            logic [2:0] c;
            r = $urandom_range(0, 99);
            c = r < 55 ? 3'b100 : r < 75 ? 3'b010 : r < 85 ? 3'b000 : 3'($urandom_range(0, 7));
            if ($urandom_range(0, 199) == 0) do_reset();
            else drive($urandom_range(0, 99) < 85, c, $urandom_range(0, 49) == 0);
        end
        @(negedge clk);
        valid = 0;
        for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL drain: got %0d pending, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
